// File: rtl/mac_loop_pkg.sv
// Shared types for the loop-driven multiply-accumulate kernel: FSM state encoding
// and the op codes shared with the fabric ALU.
package mac_loop_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_e;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] add_op        = 3'd0;
  localparam logic [OP_W-1:0] const_op      = 3'd1;
  localparam logic [OP_W-1:0] icmp_op       = 3'd2;
  localparam logic [OP_W-1:0] io_width_1_op = 3'd3;
  localparam logic [OP_W-1:0] mul_op        = 3'd4;

endpackage

// File: rtl/mac_loop_engine_addr_gen.sv
// Strided per-lane address generator with lane masking against the trip count.
// Lane addresses advance incrementally by stride*LANES each beat, so no runtime multiplier.
module mac_addr_gen #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned LANES  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    load,
  input  logic                    step,
  input  logic                    stop,
  input  logic [ADDR_W-1:0]       base,
  input  logic [ADDR_W-1:0]       stride,
  input  logic [CNT_W:0]          beat_idx,
  input  logic [CNT_W-1:0]        n,
  output logic [LANES-1:0]        lane_en,
  output logic [LANES*ADDR_W-1:0] addr
);
  import mac_loop_pkg::*;

  localparam int unsigned KW = CNT_W + 1;

  logic [ADDR_W-1:0]       stride_q;
  logic [ADDR_W-1:0]       beat_stride_c;
  logic [LANES-1:0]        mask_c;
  logic [LANES*ADDR_W-1:0] addr_load_c;
  logic [LANES*ADDR_W-1:0] addr_step_c;

  // Lane l of the beat starting at beat_idx handles element beat_idx+l
  always_comb begin
    beat_stride_c = ADDR_W'(stride_q * ADDR_W'(LANES));
    mask_c        = '0;
    addr_load_c   = '0;
    addr_step_c   = '0;
    for (int l = 0; l < LANES; l++) begin
      mask_c[l] = (beat_idx + KW'(l)) < {1'b0, n};
      addr_load_c[l*ADDR_W +: ADDR_W] = base + ADDR_W'(stride * ADDR_W'(l));
      addr_step_c[l*ADDR_W +: ADDR_W] = addr[l*ADDR_W +: ADDR_W] + beat_stride_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stride_q <= '0;
      lane_en  <= '0;
      addr     <= '0;
    end else if (en) begin
      if (load) begin
        stride_q <= stride;
        lane_en  <= mask_c;
        addr     <= addr_load_c;
      end else if (step) begin
        lane_en  <= mask_c;
        addr     <= addr_step_c;
      end else if (stop) begin
        lane_en  <= '0;
      end
    end
  end

endmodule

// File: rtl/mac_loop_engine.sv
// Loop-driven multiply-accumulate kernel: two strided read streams, LANES multipliers,
// adder tree and accumulator. Define MAC_LOOP_SATURATE_EN for signed saturating arithmetic.
module mac_loop_engine #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned LANES   = 1,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    start,
  input  logic [CNT_W-1:0]        trip_count,
  input  logic [ADDR_W-1:0]       base_a,
  input  logic [ADDR_W-1:0]       base_b,
  input  logic [ADDR_W-1:0]       stride_a,
  input  logic [ADDR_W-1:0]       stride_b,
  output logic                    busy,
  output logic                    done,
  output logic [LANES-1:0]        rd_en,
  output logic [LANES*ADDR_W-1:0] addr_a,
  output logic [LANES*ADDR_W-1:0] addr_b,
  input  logic [LANES*WIDTH-1:0]  rd_data_a,
  input  logic [LANES*WIDTH-1:0]  rd_data_b,
  output logic [WIDTH-1:0]        acc_out,
  output logic                    acc_valid,
  input  logic                    acc_ready
`ifdef MAC_LOOP_SATURATE_EN
  ,output logic                   sat_flag
`endif
);
  import mac_loop_pkg::*;

  localparam int unsigned KW = CNT_W + 1;
  localparam int unsigned DW = $clog2(MEM_LAT + 2);
  localparam int unsigned LG = $clog2(LANES);
  localparam int unsigned TL = 2 ** LG;
`ifdef MAC_LOOP_SATURATE_EN
  localparam int unsigned TW = WIDTH + LG;
  localparam logic signed [2*WIDTH-1:0] PMAX = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [2*WIDTH-1:0] PMIN = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic signed [TW:0]        AMAX = {{(TW-WIDTH+2){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [TW:0]        AMIN = {{(TW-WIDTH+2){1'b1}}, {(WIDTH-1){1'b0}}};
`else
  localparam int unsigned TW = WIDTH;
`endif

  state_e           state_q, state_d;
  logic [KW-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0] n_q;
  logic [DW-1:0]    drain_q, drain_d;
  logic             load_c, step_c, stop_c, ack_c;
  logic [CNT_W-1:0] n_mask_c;
  logic [LANES-1:0] lane_en_a, lane_en_b;

  // Loop controller: trip-count issue, fixed-length drain, result handshake
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    drain_d = drain_q;
    load_c  = 1'b0;
    step_c  = 1'b0;
    stop_c  = 1'b0;
    ack_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load_c  = 1'b1;
          idx_d   = '0;
          drain_d = '0;
          state_d = (trip_count == '0) ? HOLD : ISSUE;
        end
      end
      ISSUE: begin
        if ((idx_q + KW'(LANES)) >= {1'b0, n_q}) begin
          stop_c  = 1'b1;
          drain_d = '0;
          state_d = DRAIN;
        end else begin
          step_c  = 1'b1;
          idx_d   = idx_q + KW'(LANES);
        end
      end
      DRAIN: begin
        if (drain_q == DW'(MEM_LAT + 1)) begin
          state_d = HOLD;
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      HOLD: begin
        if (acc_ready) begin
          ack_c   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      n_q       <= '0;
      drain_q   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      acc_valid <= 1'b0;
    end else if (en) begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      drain_q   <= drain_d;
      if (load_c) n_q <= trip_count;
      busy      <= (state_d != IDLE);
      done      <= ack_c;
      acc_valid <= (state_d == HOLD);
    end
  end

  // Masking needs the fresh trip count on the launch edge, the latched one afterwards
  assign n_mask_c = load_c ? trip_count : n_q;

  mac_addr_gen #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .LANES(LANES)) u_gen_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .load     (load_c),
    .step     (step_c),
    .stop     (stop_c),
    .base     (base_a),
    .stride   (stride_a),
    .beat_idx (idx_d),
    .n        (n_mask_c),
    .lane_en  (lane_en_a),
    .addr     (addr_a)
  );

  mac_addr_gen #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .LANES(LANES)) u_gen_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .load     (load_c),
    .step     (step_c),
    .stop     (stop_c),
    .base     (base_b),
    .stride   (stride_b),
    .beat_idx (idx_d),
    .n        (n_mask_c),
    .lane_en  (lane_en_b),
    .addr     (addr_b)
  );

  assign rd_en = lane_en_a & lane_en_b & {LANES{en}};

  // Lane valid bits follow the read data through the memory latency
  logic [LANES-1:0] vpipe_q [MEM_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < MEM_LAT; s++) vpipe_q[s] <= '0;
    end else if (en) begin
      vpipe_q[0] <= lane_en_a & lane_en_b;
      for (int s = 1; s < MEM_LAT; s++) vpipe_q[s] <= vpipe_q[s-1];
    end
  end

  logic [WIDTH-1:0] prod_c [LANES];
  logic [WIDTH-1:0] prod_q [LANES];
  logic [LANES-1:0] pvalid_q;
`ifdef MAC_LOOP_SATURATE_EN
  logic signed [2*WIDTH-1:0] full_c [LANES];
  logic [LANES-1:0]          psat_c;
`endif

  // Per-lane multiply, low WIDTH bits (or clamped when saturating)
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
`ifdef MAC_LOOP_SATURATE_EN
      full_c[l] = (2*WIDTH)'($signed(rd_data_a[l*WIDTH +: WIDTH]))
                * (2*WIDTH)'($signed(rd_data_b[l*WIDTH +: WIDTH]));
      psat_c[l] = 1'b0;
      prod_c[l] = full_c[l][WIDTH-1:0];
      if (full_c[l] > PMAX) begin
        prod_c[l] = PMAX[WIDTH-1:0];
        psat_c[l] = 1'b1;
      end else if (full_c[l] < PMIN) begin
        prod_c[l] = PMIN[WIDTH-1:0];
        psat_c[l] = 1'b1;
      end
`else
      prod_c[l] = rd_data_a[l*WIDTH +: WIDTH] * rd_data_b[l*WIDTH +: WIDTH];
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int l = 0; l < LANES; l++) prod_q[l] <= '0;
      pvalid_q <= '0;
    end else if (en) begin
      for (int l = 0; l < LANES; l++) prod_q[l] <= prod_c[l];
      pvalid_q <= vpipe_q[MEM_LAT-1];
    end
  end

  // Adder tree over a power-of-two padded leaf set; invalid lanes contribute zero
  logic [TW-1:0] node [2*TL-1];

  for (genvar gl = 0; gl < TL; gl++) begin : g_leaf
    if (gl < LANES) begin : g_used
`ifdef MAC_LOOP_SATURATE_EN
      assign node[TL-1+gl] = pvalid_q[gl] ? TW'($signed(prod_q[gl])) : '0;
`else
      assign node[TL-1+gl] = pvalid_q[gl] ? prod_q[gl] : '0;
`endif
    end else begin : g_pad
      assign node[TL-1+gl] = '0;
    end
  end

  for (genvar gn = 0; gn < TL - 1; gn++) begin : g_node
    assign node[gn] = node[2*gn+1] + node[2*gn+2];
  end

  logic [WIDTH-1:0] acc_next_c;
`ifdef MAC_LOOP_SATURATE_EN
  logic signed [TW:0] acc_wide_c;
  logic               acc_sat_c;

  always_comb begin
    acc_wide_c = (TW+1)'($signed(acc_out)) + (TW+1)'($signed(node[0]));
    acc_sat_c  = 1'b0;
    acc_next_c = acc_wide_c[WIDTH-1:0];
    if (acc_wide_c > AMAX) begin
      acc_next_c = AMAX[WIDTH-1:0];
      acc_sat_c  = 1'b1;
    end else if (acc_wide_c < AMIN) begin
      acc_next_c = AMIN[WIDTH-1:0];
      acc_sat_c  = 1'b1;
    end
  end
`else
  assign acc_next_c = acc_out + node[0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_out  <= '0;
`ifdef MAC_LOOP_SATURATE_EN
      sat_flag <= 1'b0;
`endif
    end else if (en) begin
      if (load_c) begin
        acc_out  <= '0;
`ifdef MAC_LOOP_SATURATE_EN
        sat_flag <= 1'b0;
`endif
      end else begin
        acc_out  <= acc_next_c;
`ifdef MAC_LOOP_SATURATE_EN
        sat_flag <= sat_flag | acc_sat_c | (|(psat_c & vpipe_q[MEM_LAT-1]));
`endif
      end
    end
  end

endmodule

// File: tb/tb_mac_loop_engine.sv
// Directed bench for mac_loop_engine: one LANES=1/WIDTH=32 instance and one LANES=4/WIDTH=8
// instance, each with a latency-1 memory model whose data is a linear function of address.
module tb_mac_loop_engine;

  localparam int unsigned AW = 16;
  localparam int unsigned CW = 16;
  localparam int unsigned W1 = 32;
  localparam int unsigned W4 = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  int unsigned a_mul, a_add, b_mul, b_add;

  // Instance 1: LANES=1, WIDTH=32
  logic          en1, start1, busy1, done1, accv1, accr1;
  logic [CW-1:0] trip1;
  logic [AW-1:0] base_a1, base_b1, stride_a1, stride_b1, addr_a1, addr_b1;
  logic [0:0]    rd_en1;
  logic [W1-1:0] rda1, rdb1, acc1;
`ifdef MAC_LOOP_SATURATE_EN
  logic          sat1;
`endif

  // Instance 4: LANES=4, WIDTH=8
  logic            en4, start4, busy4, done4, accv4, accr4;
  logic [CW-1:0]   trip4;
  logic [AW-1:0]   base_a4, base_b4, stride_a4, stride_b4;
  logic [4*AW-1:0] addr_a4, addr_b4;
  logic [3:0]      rd_en4;
  logic [4*W4-1:0] rda4, rdb4;
  logic [W4-1:0]   acc4;
`ifdef MAC_LOOP_SATURATE_EN
  logic            sat4;
`endif

  mac_loop_engine #(.WIDTH(W1), .ADDR_W(AW), .CNT_W(CW), .LANES(1), .MEM_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en1), .start(start1), .trip_count(trip1),
    .base_a(base_a1), .base_b(base_b1), .stride_a(stride_a1), .stride_b(stride_b1),
    .busy(busy1), .done(done1), .rd_en(rd_en1), .addr_a(addr_a1), .addr_b(addr_b1),
    .rd_data_a(rda1), .rd_data_b(rdb1), .acc_out(acc1), .acc_valid(accv1),
    .acc_ready(accr1)
`ifdef MAC_LOOP_SATURATE_EN
    , .sat_flag(sat1)
`endif
  );

  mac_loop_engine #(.WIDTH(W4), .ADDR_W(AW), .CNT_W(CW), .LANES(4), .MEM_LAT(1)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en4), .start(start4), .trip_count(trip4),
    .base_a(base_a4), .base_b(base_b4), .stride_a(stride_a4), .stride_b(stride_b4),
    .busy(busy4), .done(done4), .rd_en(rd_en4), .addr_a(addr_a4), .addr_b(addr_b4),
    .rd_data_a(rda4), .rd_data_b(rdb4), .acc_out(acc4), .acc_valid(accv4),
    .acc_ready(accr4)
`ifdef MAC_LOOP_SATURATE_EN
    , .sat_flag(sat4)
`endif
  );

  // Memory models: one-cycle latency, frozen by the shared enable, junk on unread lanes
  always @(posedge clk) begin
    if (en1) begin
      rda1 <= rd_en1[0] ? W1'(a_mul * 32'(addr_a1) + a_add) : 32'hDEAD_BEEF;
      rdb1 <= rd_en1[0] ? W1'(b_mul * 32'(addr_b1) + b_add) : 32'hDEAD_BEEF;
    end
  end

  always @(posedge clk) begin
    if (en4) begin
      for (int l = 0; l < 4; l++) begin
        rda4[l*W4 +: W4] <= rd_en4[l] ? W4'(a_mul * 32'(addr_a4[l*AW +: AW]) + a_add) : 8'hA5;
        rdb4[l*W4 +: W4] <= rd_en4[l] ? W4'(b_mul * 32'(addr_b4[l*AW +: AW]) + b_add) : 8'h5B;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Launch instance 1 and return the cycle in which acc_valid rises (-1 on timeout)
  task automatic run1(input logic [CW-1:0] n, input int stall_at, output int cyc);
    trip1  = n;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    cyc    = 1;
    while (!accv1 && cyc < 200) begin
      if (cyc == stall_at) begin
        en1 = 1'b0;
        for (int s = 0; s < 3; s++) begin
          tick();
          cyc++;
          check("stall_rd_en", 32'(rd_en1), 32'd0);
        end
        en1 = 1'b1;
      end else begin
        tick();
        cyc++;
      end
    end
    if (!accv1) cyc = -1;
  endtask

  task automatic run4(input logic [CW-1:0] n, output int cyc);
    trip4  = n;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    cyc    = 1;
    while (!accv4 && cyc < 200) begin
      tick();
      cyc++;
    end
    if (!accv4) cyc = -1;
  endtask

  task automatic ack1(input string tag);
    accr1 = 1'b1;
    tick();
    accr1 = 1'b0;
    check({tag, "_done"}, 32'(done1), 32'd1);
    check({tag, "_valid_drop"}, 32'(accv1), 32'd0);
    check({tag, "_busy_idle"}, 32'(busy1), 32'd0);
    tick();
    check({tag, "_done_pulse"}, 32'(done1), 32'd0);
  endtask

  int cyc;

  initial begin
    rst_n = 1'b0;
    en1 = 1'b1; start1 = 1'b0; accr1 = 1'b0; trip1 = '0;
    base_a1 = '0; base_b1 = '0; stride_a1 = '0; stride_b1 = '0;
    en4 = 1'b1; start4 = 1'b0; accr4 = 1'b0; trip4 = '0;
    base_a4 = '0; base_b4 = '0; stride_a4 = '0; stride_b4 = '0;
    a_mul = 0; a_add = 0; b_mul = 0; b_add = 0;
    tick();
    tick();
    check("rst_busy", 32'(busy1), 32'd0);
    check("rst_valid", 32'(accv1), 32'd0);
    check("rst_done", 32'(done1), 32'd0);
    check("rst_acc", acc1, 32'd0);
    check("rst_rd_en", 32'(rd_en4), 32'd0);
    rst_n = 1'b1;
    tick();

    // A[k]=k+1, B=2, N=20 -> 2*210 = 420 in cycle 20+1+3
    a_mul = 1; a_add = 1; b_mul = 0; b_add = 2;
    base_a1 = 16'h0000; stride_a1 = 16'd1;
    base_b1 = 16'h0100; stride_b1 = 16'd1;
    trip1 = 16'd20;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    cyc = 1;
    check("t1_busy", 32'(busy1), 32'd1);
    check("t1_rd_en_c1", 32'(rd_en1), 32'd1);
    check("t1_addr_a_c1", 32'(addr_a1), 32'h0);
    tick();
    cyc++;
    check("t1_addr_a_c2", 32'(addr_a1), 32'h1);
    check("t1_addr_b_c2", 32'(addr_b1), 32'h101);
    while (!accv1 && cyc < 200) begin
      tick();
      cyc++;
    end
    check("t1_valid_cycle", 32'(cyc), 32'd24);
    check("t1_acc", acc1, 32'd420);
`ifdef MAC_LOOP_SATURATE_EN
    check("t1_sat", 32'(sat1), 32'd0);
`endif
    tick();
    check("t1_hold", 32'(accv1), 32'd1);
    check("t1_no_done", 32'(done1), 32'd0);
    ack1("t1");
    check("t1_acc_kept", acc1, 32'd420);

    // N=0: result immediately, no reads
    run1(16'd0, -1, cyc);
    check("t3_valid_cycle", 32'(cyc), 32'd1);
    check("t3_acc", acc1, 32'd0);
    check("t3_rd_en", 32'(rd_en1), 32'd0);
    ack1("t3");

    // Enable low for three cycles mid-issue
    a_mul = 1; a_add = 1; b_mul = 0; b_add = 2;
    run1(16'd20, 5, cyc);
    check("t4_valid_cycle", 32'(cyc), 32'd27);
    check("t4_acc", acc1, 32'd420);
    ack1("t4");

    // Reset in the middle of DRAIN, then a fresh run
    trip1  = 16'd20;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    cyc = 1;
    while (cyc < 21) begin
      tick();
      cyc++;
    end
    check("t5_busy_pre", 32'(busy1), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_busy", 32'(busy1), 32'd0);
    check("t5_rst_valid", 32'(accv1), 32'd0);
    check("t5_rst_acc", acc1, 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t5_no_done", 32'(done1 | accv1), 32'd0);
    end
    a_mul = 0; a_add = 3; b_mul = 0; b_add = 3;
    run1(16'd4, -1, cyc);
    check("t5_valid_cycle", 32'(cyc), 32'd8);
    check("t5_acc", acc1, 32'd36);
    ack1("t5");

    // Four lanes, N=6: second beat masked to 4'b0011
    a_mul = 0; a_add = 1; b_mul = 0; b_add = 1;
    base_a4 = 16'h0010; stride_a4 = 16'd1;
    base_b4 = 16'h0200; stride_b4 = 16'd4;
    trip4  = 16'd6;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    cyc = 1;
    check("t2_rd_en_b1", 32'(rd_en4), 32'hF);
    check("t2_addr_b_l3_b1", 32'(addr_b4[3*AW +: AW]), 32'h20C);
    tick();
    cyc++;
    check("t2_rd_en_b2", 32'(rd_en4), 32'h3);
    check("t2_addr_a_l1_b2", 32'(addr_a4[1*AW +: AW]), 32'h15);
    check("t2_addr_b_l1_b2", 32'(addr_b4[1*AW +: AW]), 32'h214);
    tick();
    cyc++;
    check("t2_rd_en_drain", 32'(rd_en4), 32'h0);
    while (!accv4 && cyc < 200) begin
      tick();
      cyc++;
    end
    check("t2_valid_cycle", 32'(cyc), 32'd6);
    check("t2_acc", 32'(acc4), 32'd6);
`ifdef MAC_LOOP_SATURATE_EN
    check("t2_sat", 32'(sat4), 32'd0);
`endif
    accr4 = 1'b1;
    tick();
    accr4 = 1'b0;
    check("t2_done", 32'(done4), 32'd1);
    check("t2_busy_idle", 32'(busy4), 32'd0);
    tick();

    // 100*100 in 8 bits: clamps when saturating, wraps to 0x10 per product otherwise
    a_mul = 0; a_add = 100; b_mul = 0; b_add = 100;
    run4(16'd4, cyc);
    check("t6_valid_cycle", 32'(cyc), 32'd5);
`ifdef MAC_LOOP_SATURATE_EN
    check("t6_acc", 32'(acc4), 32'd127);
    check("t6_sat", 32'(sat4), 32'd1);
`else
    check("t6_acc", 32'(acc4), 32'h40);
`endif
    accr4 = 1'b1;
    tick();
    accr4 = 1'b0;
    check("t6_done", 32'(done4), 32'd1);
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
